// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and FSM encoding for board button/switch conditioners
package board_io_pkg;

  // Board oscillator frequency, shared by every conditioner on this board
  localparam int CLK_HZ = 100_000_000;

  // 10 ms of stable level at CLK_HZ before a change is accepted
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Debounce FSM encoding
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = IDLE,
    ST_PRESS_WAIT   = PRESS_WAIT,
    ST_HELD         = HELD,
    ST_RELEASE_WAIT = RELEASE_WAIT
  } btn_state_e;

  // Converts a debounce window in milliseconds to clock cycles
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with synchronous reset to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_step_pulse.sv
// rtl/button_step_pulse.sv - debounced single-step strobe for the program counter
module button_step_pulse
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic step_pulse,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Last count before a level change is accepted; entry already counts as sample 1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  logic [CNT_W-1:0] cnt;
  btn_state_e       state;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (s2)
  );

  // Saturating increment so a stuck count can never wrap back into range
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_ONE;
  endfunction

  // Debounce FSM with registered level and one-shot strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      step_pulse <= 1'b0;
      btn_level  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          btn_level <= 1'b0;
          if (s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end

        ST_PRESS_WAIT: begin
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= ST_HELD;
            cnt        <= '0;
            step_pulse <= 1'b1;
            btn_level  <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ST_HELD: begin
          btn_level <= 1'b1;
          if (!s2) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end

        ST_RELEASE_WAIT: begin
          if (s2) begin
            state     <= ST_HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt       <= sat_inc(cnt);
            btn_level <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_step_pulse.sv
// tb/tb_button_step_pulse.sv - scoreboard bench for button_step_pulse with DEBOUNCE_CYCLES=4
module tb_button_step_pulse;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic step_pulse;
  logic btn_level;

  int edge_no = 0;
  int n_total = 0;
  int n_pass  = 0;

  // expected edge numbers at which step_pulse goes high
  int exp_pulse_q[$];

  // stand-in for program_counter: wraps 0..5
  logic       pc_clr;
  logic [2:0] pc_address;

  button_step_pulse #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .step_pulse(step_pulse),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  // number of the most recent rising edge
  always @(posedge clk) edge_no <= edge_no + 1;

  // program counter consumer of the strobe
  always @(posedge clk) begin
    if (pc_clr) pc_address <= 3'd0;
    else if (step_pulse) pc_address <= (pc_address == 3'd5) ? 3'd0 : pc_address + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    else n_pass++;
  endtask

  // pulse monitor: pops the scoreboard on every observed strobe
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (step_pulse) begin
      if (prev_pulse) chk("pulse_width", 2, 1);
      else if (exp_pulse_q.size() == 0) chk("unexpected_pulse_edge", edge_no, 0);
      else chk("pulse_edge", edge_no, exp_pulse_q.pop_front());
    end
    prev_pulse = step_pulse;
  end

  task automatic wait_edge(input int target);
    while (edge_no < target) @(negedge clk);
  endtask

  // drive a clean press; returns N, the edge where s1 first captures 1
  task automatic press(output int n);
    btn_in = 1'b1;
    n = edge_no + 1;
    exp_pulse_q.push_back(n + DB + 1);
  endtask

  task automatic release_check(input string tag);
    int m;
    btn_in = 1'b0;
    m = edge_no + 1;
    wait_edge(m + DB);
    chk({tag, "_lvl_before"}, btn_level, 1);
    wait_edge(m + DB + 1);
    chk({tag, "_lvl_fall"}, btn_level, 0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [2:0] pc_exp [7];
    pc_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

    reset  = 1'b1;
    btn_in = 1'b0;
    pc_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pulse", step_pulse, 0);
    chk("reset_level", btn_level, 0);
    reset  = 1'b0;
    pc_clr = 1'b0;

    // clean press captured at edge 10, pulse at edge 15
    wait_edge(9);
    press(n);
    wait_edge(14);
    chk("clean_lvl_14", btn_level, 0);
    chk("clean_pulse_14", step_pulse, 0);
    wait_edge(15);
    chk("clean_lvl_15", btn_level, 1);
    wait_edge(16);
    chk("clean_pulse_16", step_pulse, 0);

    // hold 50 cycles without repeat, then clean release
    repeat (50) @(negedge clk);
    chk("hold_lvl", btn_level, 1);
    release_check("hold_rel");
    repeat (10) @(negedge clk);

    // bounce rejection
    seen = 1'b0;
    btn_in = 1'b1; @(negedge clk);
    btn_in = 1'b0; @(negedge clk);
    btn_in = 1'b1; @(negedge clk);
    btn_in = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | btn_level;
    end
    chk("bounce_level", seen, 0);

    // release bounce while held
    press(n);
    wait_edge(n + DB + 6);
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    seen = 1'b1;
    repeat (15) begin
      @(negedge clk);
      seen = seen & btn_level;
    end
    chk("rel_bounce_level", seen, 1);
    release_check("rel_bounce_rel");
    repeat (10) @(negedge clk);

    // reset in PRESS_WAIT with cnt=2, button still held
    btn_in = 1'b1;
    n = edge_no + 1;
    wait_edge(n + 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_pulse", step_pulse, 0);
    chk("midreset_level", btn_level, 0);
    reset = 1'b0;
    n = edge_no + 1;
    exp_pulse_q.push_back(n + DB + 1);
    wait_edge(n + DB);
    chk("midreset_lvl_pre", btn_level, 0);
    wait_edge(n + DB + 1);
    chk("midreset_lvl", btn_level, 1);
    repeat (5) @(negedge clk);
    release_check("midreset_rel");
    repeat (10) @(negedge clk);

    // PC integration: 7 presses
    pc_clr = 1'b1;
    @(negedge clk);
    pc_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      press(n);
      wait_edge(n + DB + 4);
      chk($sformatf("pc_%0d", i), pc_address, pc_exp[i]);
      btn_in = 1'b0;
      repeat (DB + 6) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("pending_pulses", exp_pulse_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
